mem_burst_scheduler: RTL and testbench

- Shares one single-port memory (nonce/message scratch RAM) between NUM_CLIENTS requesters: SHA cores and the host DMA path.
- Picks one requester round-robin and gives it the memory for a whole multi-beat burst.
- Drives the memory port beat by beat.
- Routes read data back to the owning client after a fixed memory latency.

---
 rtl/mem_burst_scheduler.sv | 145 ++++++++++++++
 tb/tb_mem_burst_scheduler.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_scheduler.sv
// Purpose: round-robin arbiter that lends one single-port RAM to a client for a whole multi-beat burst.
// Latency: first cl_gnt one cycle after selection; cl_rvalid MEM_LATENCY cycles after each read beat.
// Backpressure: the owner holds cl_req per beat; dropping it mid-burst aborts the burst (issued reads still return).
// Ports: cl_req/cl_wr/cl_addr/cl_len/cl_wdata are per-client request slices; cl_gnt one-hot beat accept;
//        cl_rvalid/cl_rdata read return; mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata RAM port; busy = burst active.
module mem_burst_scheduler #(
   parameter int NUM_CLIENTS = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int LEN_WIDTH   = 3,
   parameter int MEM_LATENCY = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CLIENTS-1:0]            cl_req,
   input  logic [NUM_CLIENTS-1:0]            cl_wr,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
   input  logic [NUM_CLIENTS*LEN_WIDTH-1:0]  cl_len,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_wdata,
   output logic [NUM_CLIENTS-1:0]            cl_gnt,
   output logic [NUM_CLIENTS-1:0]            cl_rvalid,
   output logic [DATA_WIDTH-1:0]             cl_rdata,
   output logic                              mem_en,
   output logic                              mem_wr,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic [DATA_WIDTH-1:0]             mem_wdata,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic                              busy
);
   localparam int OWN_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state, state_nxt;
   logic [OWN_W-1:0]      owner, last_owner, sel;
   logic                  sel_vld;
   logic [ADDR_WIDTH-1:0] base;
   logic [LEN_WIDTH-1:0]  len, beat_cnt;
   logic                  wr;
   logic                  beat;
   logic [MEM_LATENCY-1:0] rd_vld;
   logic [OWN_W-1:0]      rd_own [MEM_LATENCY];

   // Round-robin pick: scan from the client after last_owner, so the previous
   // owner is always considered last.
   always_comb begin
      int idx;
      idx     = 0;
      sel     = last_owner;
      sel_vld = 1'b0;
      for (int k = 1; k <= NUM_CLIENTS; k++) begin
         idx = int'(last_owner) + k;
         if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
         if (!sel_vld && cl_req[idx[OWN_W-1:0]]) begin
            sel     = idx[OWN_W-1:0];
            sel_vld = 1'b1;
         end
      end
   end

   // Next state and memory-side outputs. A beat is issued only while the owner
   // keeps its request up; a low request in BURST is an abort.
   always_comb begin
      state_nxt = state;
      beat      = 1'b0;
      cl_gnt    = '0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (sel_vld) state_nxt = BURST;
         end
         BURST: begin
            if (cl_req[owner]) begin
               beat          = 1'b1;
               mem_en        = 1'b1;
               mem_wr        = wr;
               mem_addr      = base + ADDR_WIDTH'(beat_cnt);
               mem_wdata     = cl_wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
               cl_gnt[owner] = 1'b1;
               if (beat_cnt == len) state_nxt = IDLE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == BURST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= OWN_W'(NUM_CLIENTS - 1);
         owner      <= '0;
         base       <= '0;
         len        <= '0;
         wr         <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         state <= state_nxt;
         // Burst parameters are captured once here and never re-sampled mid-burst.
         if (state == IDLE && sel_vld) begin
            owner    <= sel;
            base     <= cl_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            len      <= cl_len[int'(sel)*LEN_WIDTH +: LEN_WIDTH];
            wr       <= cl_wr[sel];
            beat_cnt <= '0;
         end
         if (state == BURST) begin
            if (beat && beat_cnt != len) beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            if (state_nxt == IDLE) last_owner <= owner;
         end
      end
   end

   // Read return tracker: one slot per cycle of memory latency, so returns
   // come back in issue order even after ownership has moved on.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld <= '0;
         for (int i = 0; i < MEM_LATENCY; i++) rd_own[i] <= '0;
      end else begin
         rd_vld[0] <= beat && !wr;
         rd_own[0] <= owner;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            rd_vld[i] <= rd_vld[i-1];
            rd_own[i] <= rd_own[i-1];
         end
      end
   end

   always_comb begin
      cl_rvalid = '0;
      cl_rdata  = '0;
      if (rd_vld[MEM_LATENCY-1]) begin
         cl_rvalid[rd_own[MEM_LATENCY-1]] = 1'b1;
         cl_rdata                         = mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Purpose: randomized and directed stimulus for mem_burst_scheduler against a transaction-level reference model.
// Latency: model predicts every output each cycle; reads return MEM_LATENCY cycles after their beat.
// Backpressure: bench clients hold cl_req per burst and may drop it early to exercise aborts.
module tb_mem_burst_scheduler;
   localparam int NC = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int LW = 3;
   localparam int ML = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NC-1:0]    cl_req, cl_wr, cl_gnt, cl_rvalid;
   logic [NC*AW-1:0] cl_addr;
   logic [NC*LW-1:0] cl_len;
   logic [NC*DW-1:0] cl_wdata;
   logic [DW-1:0]    cl_rdata, mem_wdata, mem_rdata;
   logic             mem_en, mem_wr, busy;
   logic [AW-1:0]    mem_addr;

   mem_burst_scheduler #(
      .NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MEM_LATENCY(ML)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cl_req(cl_req), .cl_wr(cl_wr), .cl_addr(cl_addr),
      .cl_len(cl_len), .cl_wdata(cl_wdata), .cl_gnt(cl_gnt), .cl_rvalid(cl_rvalid),
      .cl_rdata(cl_rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Client intentions
   bit            c_act   [NC];
   bit            c_wr    [NC];
   logic [AW-1:0] c_addr  [NC];
   int            c_len   [NC];
   int            c_done  [NC];
   int            c_abort [NC];
   logic [DW-1:0] c_wd    [NC][8];

   // Reference model: who owns the RAM, how far into the burst, and which
   // read returns are still owed (cycle due, client).
   bit            m_busy = 1'b0;
   bit            m_wr;
   int            m_owner, m_cnt, m_len;
   int            m_last = NC - 1;
   logic [AW-1:0] m_base;
   int            rq_due[$];
   int            rq_own[$];

   typedef logic [2*NC+3+AW+2*DW-1:0] snap_t;
   snap_t exp_snap;

   function automatic snap_t obs();
      return {cl_gnt, cl_rvalid, mem_en, mem_wr, busy, mem_addr, mem_wdata, cl_rdata};
   endfunction

   task automatic arm(input int i, input bit wr, input logic [AW-1:0] addr, input int len, input int abort_at);
      c_act[i]   = 1'b1;
      c_wr[i]    = wr;
      c_addr[i]  = addr;
      c_len[i]   = len;
      c_done[i]  = 0;
      c_abort[i] = abort_at;
      for (int b = 0; b < 8; b++) c_wd[i][b] = $urandom;
   endtask

   // Clients show their request fields only while waiting; during their own
   // burst those fields carry junk, which the DUT must not pick up.
   task automatic drive();
      for (int i = 0; i < NC; i++) begin
         cl_req[i] = c_act[i] && (c_done[i] != c_abort[i]);
         if (c_act[i] && !(m_busy && m_owner == i)) begin
            cl_wr[i]             = c_wr[i];
            cl_addr[i*AW +: AW]  = c_addr[i];
            cl_len[i*LW +: LW]   = LW'(c_len[i]);
         end else begin
            cl_wr[i]             = 1'($urandom);
            cl_addr[i*AW +: AW]  = AW'($urandom);
            cl_len[i*LW +: LW]   = LW'($urandom);
         end
         cl_wdata[i*DW +: DW] = c_act[i] ? c_wd[i][c_done[i] & 7] : $urandom;
      end
      mem_rdata = $urandom;
   endtask

   task automatic predict();
      logic [NC-1:0] g, rv;
      logic          en, wr;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, rd;
      g = '0; rv = '0; en = 1'b0; wr = 1'b0; a = '0; wd = '0; rd = '0;
      if (m_busy && cl_req[m_owner]) begin
         en         = 1'b1;
         wr         = m_wr;
         a          = m_base + AW'(m_cnt);
         wd         = c_wd[m_owner][m_cnt];
         g[m_owner] = 1'b1;
      end
      if (rq_due.size() > 0 && rq_due[0] == cyc) begin
         rv[rq_own[0]] = 1'b1;
         rd            = mem_rdata;
      end
      exp_snap = {g, rv, en, wr, m_busy, a, wd, rd};
   endtask

   task automatic advance();
      bit found;
      @(posedge clk);
      if (rq_due.size() > 0 && rq_due[0] == cyc) begin
         void'(rq_due.pop_front());
         void'(rq_own.pop_front());
      end
      if (!rst_n) begin
         m_busy = 1'b0;
         m_last = NC - 1;
         rq_due.delete();
         rq_own.delete();
         for (int i = 0; i < NC; i++) c_done[i] = 0;
      end else if (!m_busy) begin
         found = 1'b0;
         for (int k = 1; k <= NC; k++) begin
            if (!found && cl_req[(m_last + k) % NC]) begin
               found   = 1'b1;
               m_owner = (m_last + k) % NC;
            end
         end
         if (found) begin
            m_busy = 1'b1;
            m_base = c_addr[m_owner];
            m_len  = c_len[m_owner];
            m_wr   = c_wr[m_owner];
            m_cnt  = 0;
         end
      end else if (cl_req[m_owner]) begin
         if (!m_wr) begin
            rq_due.push_back(cyc + ML);
            rq_own.push_back(m_owner);
         end
         c_done[m_owner]++;
         if (m_cnt == m_len) begin
            m_busy = 1'b0;
            m_last = m_owner;
            c_act[m_owner] = 1'b0;
         end else begin
            m_cnt++;
         end
      end else begin
         m_busy = 1'b0;
         m_last = m_owner;
         c_act[m_owner] = 1'b0;
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(); predict(); @(negedge clk);
         if (c > 0) begin
            n_vec++;
            if (obs() !== snap_t'(0)) begin
               n_err++;
               $display("FAIL reset_state: got %h expected all zero", obs());
            end
         end
         advance();
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      int first_g = -1, first_rv = -1, nrv = 0;
      bit ok;
      logic [AW-1:0] addrs[$];
      arm(2, 1'b0, 16'h0010, 3, 99);
      for (int c = 0; c < 10; c++) begin
         drive(); predict(); @(negedge clk);
         n_vec++;
         if (obs() !== exp_snap) begin
            n_err++;
            $display("FAIL single_read cycle %0d: got %h expected %h", c, obs(), exp_snap);
         end
         if (cl_gnt[2]) begin
            if (first_g < 0) first_g = c;
            addrs.push_back(mem_addr);
         end
         if (cl_rvalid[2]) begin
            if (first_rv < 0) first_rv = c;
            nrv++;
         end
         advance();
      end
      n_vec++;
      if (first_g != 1) begin
         n_err++;
         $display("FAIL single_read_grant_latency: first grant in cycle %0d, expected 1", first_g);
      end
      ok = (addrs.size() == 4);
      for (int k = 0; k < addrs.size(); k++) if (addrs[k] !== AW'(16 + k)) ok = 1'b0;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL single_read_addrs: %0d beats seen, expected 4 at 0x0010..0x0013", addrs.size());
      end
      n_vec++;
      if (nrv != 4 || first_rv != 1 + ML) begin
         n_err++;
         $display("FAIL single_read_rvalid: %0d returns first at cycle %0d, expected 4 first at %0d", nrv, first_rv, 1 + ML);
      end
   endtask

   task automatic test_round_robin();
      int owners[$];
      int exp_own[6] = '{0, 1, 3, 0, 1, 3};
      bit ok;
      rst_n = 1'b0; drive(); advance(); rst_n = 1'b1;
      arm(0, 1'b0, AW'($urandom), 0, 99);
      arm(1, 1'b0, AW'($urandom), 0, 99);
      arm(3, 1'b0, AW'($urandom), 0, 99);
      for (int c = 0; c < 12; c++) begin
         drive(); predict(); @(negedge clk);
         n_vec++;
         if (obs() !== exp_snap) begin
            n_err++;
            $display("FAIL round_robin cycle %0d: got %h expected %h", c, obs(), exp_snap);
         end
         for (int i = 0; i < NC; i++) if (cl_gnt[i]) owners.push_back(i);
         advance();
         if (c < 10) begin
            if (!c_act[0]) arm(0, 1'b0, AW'($urandom), 0, 99);
            if (!c_act[1]) arm(1, 1'b0, AW'($urandom), 0, 99);
            if (!c_act[3]) arm(3, 1'b0, AW'($urandom), 0, 99);
         end
      end
      ok = (owners.size() == 6);
      for (int k = 0; k < owners.size() && k < 6; k++) if (owners[k] != exp_own[k]) ok = 1'b0;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL round_robin_order: %0d grants, first owner %0d, expected 6 grants ordered 0,1,3,0,1,3",
                  owners.size(), owners.size() > 0 ? owners[0] : -1);
      end
      for (int c = 0; c < 6; c++) begin
         drive(); predict(); @(negedge clk);
         n_vec++;
         if (obs() !== exp_snap) begin
            n_err++;
            $display("FAIL round_robin_drain cycle %0d: got %h expected %h", c, obs(), exp_snap);
         end
         advance();
      end
   endtask

   task automatic test_write_wrap();
      logic [AW-1:0] exp_a[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
      logic [DW-1:0] exp_d[3] = '{32'hA, 32'hB, 32'hC};
      int nb = 0, nrv = 0;
      bit ok = 1'b1;
      arm(1, 1'b1, 16'hFFFE, 2, 99);
      c_wd[1][0] = 32'hA; c_wd[1][1] = 32'hB; c_wd[1][2] = 32'hC;
      for (int c = 0; c < 8; c++) begin
         drive(); predict(); @(negedge clk);
         n_vec++;
         if (obs() !== exp_snap) begin
            n_err++;
            $display("FAIL write_wrap cycle %0d: got %h expected %h", c, obs(), exp_snap);
         end
         if (cl_gnt[1]) begin
            if (nb > 2 || mem_addr !== exp_a[nb] || mem_wdata !== exp_d[nb] || mem_wr !== 1'b1) ok = 1'b0;
            nb++;
         end
         if (cl_rvalid != '0) nrv++;
         advance();
      end
      n_vec++;
      if (!ok || nb != 3 || nrv != 0) begin
         n_err++;
         $display("FAIL write_wrap_beats: %0d beats, %0d returns, match=%0d; expected 3 beats FFFE/FFFF/0000 with A/B/C, 0 returns",
                  nb, nrv, ok);
      end
   endtask

   task automatic test_abort();
      int g0 = 0, rv0 = 0, next_owner = -1;
      arm(0, 1'b0, AW'($urandom), 7, 3);
      arm(1, 1'b0, AW'($urandom), 1, 99);
      for (int c = 0; c < 18; c++) begin
         drive(); predict(); @(negedge clk);
         n_vec++;
         if (obs() !== exp_snap) begin
            n_err++;
            $display("FAIL abort cycle %0d: got %h expected %h", c, obs(), exp_snap);
         end
         if (cl_gnt[0]) g0++;
         else if (cl_gnt != '0 && next_owner < 0) next_owner = cl_gnt[1] ? 1 : (cl_gnt[2] ? 2 : 3);
         if (cl_rvalid[0]) rv0++;
         advance();
      end
      n_vec++;
      if (g0 != 3 || rv0 != 3) begin
         n_err++;
         $display("FAIL abort_counts: %0d grants %0d returns, expected 3 and 3", g0, rv0);
      end
      n_vec++;
      if (next_owner != 1) begin
         n_err++;
         $display("FAIL abort_next_owner: got %0d expected 1", next_owner);
      end
   endtask

   task automatic test_overlap();
      bit seen = 1'b0;
      int rv1 = 0;
      arm(0, 1'b0, AW'($urandom), 1, 99);
      arm(1, 1'b1, AW'($urandom), 1, 99);
      for (int c = 0; c < 10; c++) begin
         drive(); predict(); @(negedge clk);
         n_vec++;
         if (obs() !== exp_snap) begin
            n_err++;
            $display("FAIL overlap cycle %0d: got %h expected %h", c, obs(), exp_snap);
         end
         if (cl_gnt[1] && cl_rvalid[0]) seen = 1'b1;
         if (cl_rvalid[1]) rv1++;
         advance();
      end
      n_vec++;
      if (!seen || rv1 != 0) begin
         n_err++;
         $display("FAIL overlap_return: overlap seen=%0d client1 returns=%0d, expected 1 and 0", seen, rv1);
      end
   endtask

   task automatic test_reset_mid();
      int first_after = -1, lost = 0;
      arm(2, 1'b0, AW'($urandom), 7, 99);
      arm(0, 1'b0, AW'($urandom), 0, 99);
      arm(1, 1'b0, AW'($urandom), 0, 99);
      for (int c = 0; c < 20; c++) begin
         rst_n = (c != 2);
         drive(); predict(); @(negedge clk);
         n_vec++;
         if (obs() !== exp_snap) begin
            n_err++;
            $display("FAIL reset_mid cycle %0d: got %h expected %h", c, obs(), exp_snap);
         end
         if (c == 3) begin
            n_vec++;
            if (obs() !== snap_t'(0)) begin
               n_err++;
               $display("FAIL reset_mid_outputs: got %h expected all zero", obs());
            end
         end
         if (c >= 3 && c <= 4 && cl_rvalid != '0) lost++;
         if (c >= 3 && first_after < 0 && cl_gnt != '0)
            first_after = cl_gnt[0] ? 0 : (cl_gnt[1] ? 1 : (cl_gnt[2] ? 2 : 3));
         advance();
      end
      rst_n = 1'b1;
      n_vec++;
      if (lost != 0 || first_after != 0) begin
         n_err++;
         $display("FAIL reset_mid_recovery: %0d stale returns, first owner %0d; expected 0 and 0", lost, first_after);
      end
   endtask

   task automatic test_random();
      int len;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < NC; i++) begin
            if (!c_act[i] && $urandom_range(3) == 0) begin
               len = $urandom_range(7);
               arm(i, 1'($urandom_range(1)), AW'($urandom), len,
                   (len > 0 && $urandom_range(3) == 0) ? int'($urandom_range(len, 1)) : 99);
            end
         end
         rst_n = ($urandom_range(249) != 0);
         drive(); predict(); @(negedge clk);
         n_vec++;
         if (obs() !== exp_snap) begin
            n_err++;
            $display("FAIL random cycle %0d: got %h expected %h", c, obs(), exp_snap);
         end
         advance();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      cl_req    = '0;
      cl_wr     = '0;
      cl_addr   = '0;
      cl_len    = '0;
      cl_wdata  = '0;
      mem_rdata = '0;
      for (int i = 0; i < NC; i++) begin
         c_act[i]   = 1'b0;
         c_done[i]  = 0;
         c_abort[i] = 99;
      end
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_wrap();
      test_abort();
      test_overlap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
